// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbitrated adder/subtractor.
package adder_arbiter_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  // Operand slicing works on a widened bus so one function serves any WIDTH/NREQ.
  localparam int MAXW   = 64;
  localparam int MAXN   = 16;
  localparam int MAXBUS = MAXW * MAXN;

  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAXW-1:0] sel_op(input logic [MAXBUS-1:0] flat_bus,
                                             input int unsigned idx,
                                             input int unsigned w);
    logic [MAXBUS-1:0] sh;
    sh = flat_bus >> (idx * w);
    return sh[MAXW-1:0];
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the clients, the consumer and the shared adder.
interface adder_arbiter_if import adder_arbiter_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]       ReqValid;
  logic [NREQ-1:0]       ReqReady;
  logic [NREQ*WIDTH-1:0] ReqA;
  logic [NREQ*WIDTH-1:0] ReqB;
  logic [NREQ-1:0]       ReqSub;
  logic                  RespValid;
  logic                  RespReady;
  logic [IDW-1:0]        RespId;
  logic [WIDTH-1:0]      OutSum;
  logic                  CarryOut;
  logic                  OverFlow;

  modport master (output ReqValid, ReqA, ReqB, ReqSub, RespReady,
                  input  ReqReady, RespValid, RespId, OutSum, CarryOut, OverFlow);
  modport slave  (input  ReqValid, ReqA, ReqB, ReqSub, RespReady,
                  output ReqReady, RespValid, RespId, OutSum, CarryOut, OverFlow);
endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last accepted grant and wraps.
module rr_arbiter import adder_arbiter_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          Req,
  input  logic                     Advance,
  output logic [NREQ-1:0]          Grant,
  output logic [idw(NREQ)-1:0]     GrantIdx
);
  localparam int IDW = idw(NREQ);

  logic [IDW-1:0] last_q, last_d;
  logic           found;
  logic [IDW-1:0] jidx;
  int             j;

  always_comb begin
    Grant    = '0;
    GrantIdx = last_q;
    found    = 1'b0;
    j        = 0;
    jidx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last_q) + k;
      if (j >= NREQ) j = j - NREQ;
      jidx = IDW'(j);
      if (!found && Req[jidx]) begin
        found       = 1'b1;
        Grant[jidx] = 1'b1;
        GrantIdx    = jidx;
      end
    end
  end

  assign last_d = Advance ? GrantIdx : last_q;

  // Reset to NREQ-1 so requester 0 is searched first.
  always_ff @(posedge Clk) begin
    if (Reset) last_q <= IDW'(NREQ - 1);
    else       last_q <= last_d;
  end
endmodule

// File: rtl/adder_arbiter.sv
// One shared WIDTH-bit add/sub unit, granted round-robin, with a one-deep tagged result register.
module adder_arbiter import adder_arbiter_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input logic            Clk,
  input logic            Reset,
  adder_arbiter_if.slave bus
);
  localparam int IDW = idw(NREQ);

  state_e           state_q, state_d;
  logic             open, accept;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic [WIDTH-1:0] a, b, bx;
  logic             cin;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d, ov_q, ov_d;
  logic [IDW-1:0]   id_q, id_d;

  // Gating with !Reset keeps ReqReady low so nothing completes in a reset cycle.
  assign open   = !Reset && (state_q == EMPTY || bus.RespReady);
  assign accept = |grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (bus.ReqValid & {NREQ{open}}),
    .Advance  (accept),
    .Grant    (grant),
    .GrantIdx (gidx)
  );

  assign a    = WIDTH'(sel_op(MAXBUS'(bus.ReqA), int'(gidx), WIDTH));
  assign b    = WIDTH'(sel_op(MAXBUS'(bus.ReqB), int'(gidx), WIDTH));
  assign cin  = bus.ReqSub[gidx];
  assign bx   = cin ? ~b : b;
  assign full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;
    id_d    = id_q;
    if (accept) begin
      state_d = FULL;
      sum_d   = full[WIDTH-1:0];
      co_d    = full[WIDTH];
      ov_d    = (a[WIDTH-1] ^ full[WIDTH-1]) & (bx[WIDTH-1] ^ full[WIDTH-1]);
      id_d    = gidx;
    end else if (state_q == FULL && bus.RespReady) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      id_q    <= id_d;
    end
  end

  assign bus.ReqReady  = grant;
  assign bus.RespValid = (state_q == FULL);
  assign bus.RespId    = id_q;
  assign bus.OutSum    = sum_q;
  assign bus.CarryOut  = co_q;
  assign bus.OverFlow  = ov_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed checks of arbitration order, arithmetic flags, backpressure and reset for adder_arbiter.
module tb_adder_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  adder_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.ReqValid[i]      = 1'b1;
    bus.ReqA[i*W +: W]   = a;
    bus.ReqB[i*W +: W]   = b;
    bus.ReqSub[i]        = sub;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.RespReady = 1'b1;
    bus.ReqValid = '0; bus.ReqA = '0; bus.ReqB = '0; bus.ReqSub = '0;
    for (int i = 0; i < N; i++) set_req(i, W'(i * 16 + 1), 16'h0001, 1'b0);
    tick(); tick();
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.RespValid); end
    total++; if (bus.ReqReady !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.ReqReady); end
    total++; if (bus.OutSum !== 16'h0000 || bus.CarryOut !== 1'b0 || bus.OverFlow !== 1'b0 || bus.RespId !== 2'd0) begin
      bad++; $display("FAIL reset_result got=%h/%b/%b/%0d exp=0000/0/0/0", bus.OutSum, bus.CarryOut, bus.OverFlow, bus.RespId);
    end
  endtask

  task automatic test_round_robin();
    int g;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g = k % N;
      total++; if (bus.ReqReady !== 4'(1 << g)) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.ReqReady, 4'(1 << g)); end
      if (k > 0) begin
        total++; if (bus.RespValid !== 1'b1 || bus.RespId !== 2'((k - 1) % N) || bus.OutSum !== W'(((k - 1) % N) * 16 + 2)) begin
          bad++; $display("FAIL rr_resp%0d got=%b/%0d/%h exp=1/%0d/%h", k, bus.RespValid, bus.RespId, bus.OutSum, (k - 1) % N, ((k - 1) % N) * 16 + 2);
        end
      end
      tick();
    end
    bus.ReqValid = '0;
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b1 || bus.RespId !== 2'd0 || bus.OutSum !== 16'h0002) begin
      bad++; $display("FAIL rr_last got=%b/%0d/%h exp=1/0/0002", bus.RespValid, bus.RespId, bus.OutSum);
    end
    tick();
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b0 || bus.ReqReady !== 4'b0000) begin
      bad++; $display("FAIL rr_drain got=%b/%b exp=0/0000", bus.RespValid, bus.ReqReady);
    end
  endtask

  task automatic test_single_add();
    tick();
    set_req(1, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    total++; if (bus.ReqReady !== 4'b0010) begin bad++; $display("FAIL add_grant got=%b exp=0010", bus.ReqReady); end
    tick();
    bus.ReqValid = '0;
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b1 || bus.RespId !== 2'd1 || bus.OutSum !== 16'h8000 || bus.CarryOut !== 1'b0 || bus.OverFlow !== 1'b1) begin
      bad++; $display("FAIL add_result got=%b/%0d/%h/%b/%b exp=1/1/8000/0/1", bus.RespValid, bus.RespId, bus.OutSum, bus.CarryOut, bus.OverFlow);
    end
    tick();
  endtask

  task automatic test_subtract();
    set_req(2, 16'h0003, 16'h0005, 1'b1);
    @(negedge clk);
    total++; if (bus.ReqReady !== 4'b0100) begin bad++; $display("FAIL sub_grant got=%b exp=0100", bus.ReqReady); end
    tick();
    set_req(2, 16'h8000, 16'h0001, 1'b1);
    @(negedge clk);
    total++; if (bus.RespId !== 2'd2 || bus.OutSum !== 16'hFFFE || bus.CarryOut !== 1'b0 || bus.OverFlow !== 1'b0) begin
      bad++; $display("FAIL sub_borrow got=%0d/%h/%b/%b exp=2/FFFE/0/0", bus.RespId, bus.OutSum, bus.CarryOut, bus.OverFlow);
    end
    total++; if (bus.ReqReady !== 4'b0100) begin bad++; $display("FAIL sub_b2b_grant got=%b exp=0100", bus.ReqReady); end
    tick();
    bus.ReqValid = '0;
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b1 || bus.OutSum !== 16'h7FFF || bus.CarryOut !== 1'b1 || bus.OverFlow !== 1'b1) begin
      bad++; $display("FAIL sub_ovf got=%b/%h/%b/%b exp=1/7FFF/1/1", bus.RespValid, bus.OutSum, bus.CarryOut, bus.OverFlow);
    end
    tick();
  endtask

  task automatic test_carry_wrap();
    set_req(0, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    total++; if (bus.ReqReady !== 4'b0001) begin bad++; $display("FAIL wrap_grant got=%b exp=0001", bus.ReqReady); end
    tick();
    bus.ReqValid = '0;
    bus.RespReady = 1'b0;
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b1 || bus.RespId !== 2'd0 || bus.OutSum !== 16'h0000 || bus.CarryOut !== 1'b1 || bus.OverFlow !== 1'b0) begin
      bad++; $display("FAIL wrap_result got=%b/%0d/%h/%b/%b exp=1/0/0000/1/0", bus.RespValid, bus.RespId, bus.OutSum, bus.CarryOut, bus.OverFlow);
    end
  endtask

  task automatic test_backpressure();
    tick();
    set_req(0, 16'h0010, 16'h0020, 1'b0);
    set_req(3, 16'h0100, 16'h0001, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.ReqReady !== 4'b0000 || bus.RespValid !== 1'b1 || bus.OutSum !== 16'h0000 || bus.CarryOut !== 1'b1 || bus.RespId !== 2'd0) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%b/%h/%b/%0d exp=0000/1/0000/1/0", c, bus.ReqReady, bus.RespValid, bus.OutSum, bus.CarryOut, bus.RespId);
      end
      tick();
    end
    bus.RespReady = 1'b1;
    @(negedge clk);
    total++; if (bus.ReqReady !== 4'b1000) begin bad++; $display("FAIL bp_release_grant got=%b exp=1000", bus.ReqReady); end
    tick();
    bus.ReqValid[3] = 1'b0;
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b1 || bus.RespId !== 2'd3 || bus.OutSum !== 16'h00FF || bus.CarryOut !== 1'b1 || bus.OverFlow !== 1'b0) begin
      bad++; $display("FAIL bp_result3 got=%b/%0d/%h/%b/%b exp=1/3/00FF/1/0", bus.RespValid, bus.RespId, bus.OutSum, bus.CarryOut, bus.OverFlow);
    end
    total++; if (bus.ReqReady !== 4'b0001) begin bad++; $display("FAIL bp_next_grant got=%b exp=0001", bus.ReqReady); end
    tick();
    bus.ReqValid = '0;
    @(negedge clk);
    total++; if (bus.RespId !== 2'd0 || bus.OutSum !== 16'h0030 || bus.CarryOut !== 1'b0 || bus.OverFlow !== 1'b0) begin
      bad++; $display("FAIL bp_result0 got=%0d/%h/%b/%b exp=0/0030/0/0", bus.RespId, bus.OutSum, bus.CarryOut, bus.OverFlow);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) set_req(i, 16'h1000, W'(i), 1'b0);
    @(negedge clk);
    total++; if (bus.ReqReady !== 4'b0010) begin bad++; $display("FAIL rst_mid_pre_grant got=%b exp=0010", bus.ReqReady); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.ReqReady !== 4'b0000) begin bad++; $display("FAIL rst_mid_ready got=%b exp=0000", bus.ReqReady); end
    tick();
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b0 || bus.ReqReady !== 4'b0000 || bus.OutSum !== 16'h0000) begin
      bad++; $display("FAIL rst_mid_clear got=%b/%b/%h exp=0/0000/0000", bus.RespValid, bus.ReqReady, bus.OutSum);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.ReqReady !== 4'b0001) begin bad++; $display("FAIL rst_mid_first_grant got=%b exp=0001", bus.ReqReady); end
    tick();
    bus.ReqValid = '0;
    @(negedge clk);
    total++; if (bus.RespValid !== 1'b1 || bus.RespId !== 2'd0 || bus.OutSum !== 16'h1000) begin
      bad++; $display("FAIL rst_mid_result got=%b/%0d/%h exp=1/0/1000", bus.RespValid, bus.RespId, bus.OutSum);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_add();
    test_subtract();
    test_carry_wrap();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one WIDTH-bit two's-complement adder/subtractor between NREQ requesters under round-robin arbitration. Each requester offers an operand pair and an add/subtract flag over a valid/ready handshake. The block registers one result per grant, tagged with the requester index, and holds it on a valid/ready response port. It sits between the ALU-issue logic of several clients and the single shared arithmetic resource.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- NREQ, 4, number of requesters (2..16); IDW = max(1, $clog2(NREQ))
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  NREQ  request valid, one bit per requester
- ReqReady  output  NREQ  one-hot grant/accept; zero or one bit high per cycle
- ReqA  input  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- ReqB  input  NREQ*WIDTH  operand B, same packing
- ReqSub  input  NREQ  1 = A−B, 0 = A+B
- RespValid  output  1  result register holds an unconsumed result
- RespReady  input  1  consumer accepts result
- RespId  output  IDW  index of requester that produced the result
- OutSum  output  WIDTH  sum/difference (mod 2^WIDTH)
- CarryOut  output  1  carry out of bit WIDTH−1 (for subtract: 1 = no borrow)
- OverFlow  output  1  signed overflow
- Decided: one clock; reset is synchronous and active-high.

## Operation
- Two-state FSM: EMPTY (RespValid=0) and FULL (RespValid=1).
- Accept is allowed when `Open = !RespValid | RespReady`. When Open is high and any ReqValid bit is set, the arbiter asserts exactly one ReqReady bit (grant g). ReqReady is combinational from ReqValid, the pointer and the state.
- Round-robin: the search starts at LastGrant+1 and wraps modulo NREQ. LastGrant updates to g only on an accepted transfer.
- On accept: Bx = ReqSub[g] ? ~ReqB[g] : ReqB[g]; Cin = ReqSub[g]; {CarryOut,OutSum} <= A + Bx + Cin (WIDTH+1-bit add); OverFlow <= (A[W-1]^OutSum[W-1]) & (Bx[W-1]^OutSum[W-1]); RespId <= g; state goes to FULL.
- Transitions:
  - EMPTY: if an accept occurs, go to FULL.
  - FULL with RespReady and an accept: stay FULL with the new result (back-to-back).
  - FULL with RespReady and no request: go to EMPTY.
  - FULL with !RespReady: hold all outputs stable and keep ReqReady=0.
- No ReqValid: ReqReady=0 and the pointer is unchanged.
- Requesters must hold ReqA/ReqB/ReqSub stable while ReqValid is high and ReqReady is low. The block does not check this.
- Result registers are loaded only on an accept. When EMPTY, OutSum/CarryOut/OverFlow/RespId keep their last values and are don't-care to the consumer.

## Timing
- Reset values: RespValid=0, OutSum=0, CarryOut=0, OverFlow=0, RespId=0, LastGrant=NREQ−1 (requester 0 has priority first). ReqReady=0 while Reset is high.
- Latency: the accept edge is followed by RespValid=1 one cycle later.
- Throughput: one operation per cycle while RespReady is held high.
- Reset mid-operation: a pending result is discarded and no handshake completes in the reset cycle.
- Fairness: a requester holding ReqValid is granted within NREQ accepts.

## Structure
- Package adder_arbiter_pkg:
  - state enum {EMPTY, FULL}
  - function clog2-based IDW helper
  - function sel_op(flat_bus, idx) for operand slicing
- Sub-module rr_arbiter #(NREQ):
  - inputs: Req, Advance, Clk, Reset
  - outputs: one-hot Grant, GrantIdx
  - owns LastGrant
- The adder stays inline in the top.

## Test plan
- Single add: WIDTH=16, req1 A=0x7FFF B=0x0001 add, RespReady=1 → next cycle RespValid=1, RespId=1, OutSum=0x8000, CarryOut=0, OverFlow=1.
- Subtract: req2 A=0x0003 B=0x0005 sub → OutSum=0xFFFE, CarryOut=0 (borrow), OverFlow=0. Then A=0x8000 B=0x0001 sub → OutSum=0x7FFF, CarryOut=1, OverFlow=1.
- Round-robin: all four ReqValid held from reset with RespReady=1 → grants 0,1,2,3,0 on consecutive cycles, and RespId follows one cycle later.
- Backpressure: result FULL, RespReady=0 for 3 cycles with req0/req3 valid → ReqReady=0 and outputs stable. RespReady=1 → same-cycle grant to the next requester in round-robin order, with the new result the following cycle.
- Carry wrap: A=0xFFFF B=0x0001 add → OutSum=0x0000, CarryOut=1, OverFlow=0.
- Reset mid-stream: assert Reset while FULL with traffic → next cycle RespValid=0, ReqReady=0. After release, the first grant goes to requester 0.
